pc_gen: RTL and testbench

PC_GEN -- requirements
Module: pc_gen

---
 rtl/pc_gen_if.sv | 11 +
 rtl/pc_gen.sv | 134 +++++++++++++
 tb/tb_pc_gen.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pc_gen_if.sv
// Fetch-side PC handshake between pc_gen (master) and the fetch unit (slave).
interface pc_gen_if #(
  parameter int PC_WIDTH = 32
);
  logic [PC_WIDTH-1:0] pc_out;
  logic                pc_out_valid;
  logic                pc_out_ready;

  modport master (output pc_out, output pc_out_valid, input pc_out_ready);
  modport slave  (input pc_out, input pc_out_valid, output pc_out_ready);
endinterface

// File: rtl/pc_gen.sv
// Fetch PC generator: redirect, branch prediction and an optional return-address stack.
// Define PC_GEN_RAS_EN to build the RAS; without it call/return hints are ignored.
//
// state | meaning
// BOOT  | first cycle out of reset, PC not yet presented
// RUN   | presenting pc_q to fetch
// KILL  | one-cycle bubble after a redirect
module pc_gen #(
  parameter int PC_WIDTH   = 32,
  parameter int INC_AMOUNT = 4,
  parameter int RAS_DEPTH  = 4
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [PC_WIDTH-1:0]              reset_vector,
  input  logic                             redirect_valid,
  input  logic [PC_WIDTH-1:0]              redirect_pc,
  input  logic                             pred_valid,
  input  logic [PC_WIDTH-1:0]              pred_target,
  input  logic                             pred_is_call,
  input  logic                             pred_is_ret,
  pc_gen_if.master                         fetch,
  output logic [$clog2(RAS_DEPTH+1)-1:0]   ras_count
);

  localparam int                  CNT_W = $clog2(RAS_DEPTH+1);
  localparam logic [PC_WIDTH-1:0] INC   = PC_WIDTH'(INC_AMOUNT);

  typedef enum logic [1:0] {BOOT, RUN, KILL} state_e;

  state_e              state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [PC_WIDTH-1:0] pc_seq;
  logic [PC_WIDTH-1:0] ras_top;
  logic                accept;
  logic                ras_pop;

  assign fetch.pc_out       = pc_q;
  assign fetch.pc_out_valid = (state_q == RUN) && !redirect_valid;
  assign accept             = fetch.pc_out_valid && fetch.pc_out_ready;
  assign pc_seq             = pc_q + INC;

  always_comb begin
    state_d = state_q;
    if (redirect_valid) begin
      state_d = KILL;
    end else begin
      case (state_q)
        BOOT:    state_d = RUN;
        KILL:    state_d = RUN;
        default: state_d = RUN;
      endcase
    end
  end

  always_comb begin
    pc_d = pc_q;
    if (redirect_valid) begin
      pc_d = redirect_pc;
    end else if (accept) begin
      if (ras_pop)         pc_d = ras_top;
      else if (pred_valid) pc_d = pred_target;
      else                 pc_d = pc_seq;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= BOOT;
      pc_q    <= reset_vector;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

`ifdef PC_GEN_RAS_EN
  localparam int               PTR_W   = $clog2(RAS_DEPTH);
  localparam logic [PTR_W-1:0] PTR_MAX = PTR_W'(RAS_DEPTH-1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RAS_DEPTH);

  logic [PC_WIDTH-1:0] ras_q [RAS_DEPTH];
  logic [PC_WIDTH-1:0] ras_d [RAS_DEPTH];
  logic [PTR_W-1:0]    ptr_q, ptr_d, ptr_inc, ptr_dec;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                ras_push;

  // ptr_q is the next write slot; the stack is circular so a full push drops the oldest.
  assign ptr_inc   = (ptr_q == PTR_MAX) ? '0 : ptr_q + 1'b1;
  assign ptr_dec   = (ptr_q == '0) ? PTR_MAX : ptr_q - 1'b1;
  assign ras_top   = ras_q[ptr_dec];
  assign ras_pop   = accept && pred_is_ret && (cnt_q != '0);
  assign ras_push  = accept && pred_valid && pred_is_call;
  assign ras_count = cnt_q;

  always_comb begin
    ras_d = ras_q;
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    if (ras_pop && ras_push) begin
      ras_d[ptr_dec] = pc_seq;
    end else if (ras_pop) begin
      ptr_d = ptr_dec;
      cnt_d = cnt_q - 1'b1;
    end else if (ras_push) begin
      ras_d[ptr_q] = pc_seq;
      ptr_d        = ptr_inc;
      if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end

  // Entries are unreachable while cnt_q is zero, so they are never cleared.
  always_ff @(posedge clk) begin
    ras_q <= ras_d;
  end
`else
  logic unused_ras_hints;
  assign unused_ras_hints = pred_is_call ^ pred_is_ret;
  assign ras_pop          = 1'b0;
  assign ras_top          = '0;
  assign ras_count        = '0;
`endif

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: directed scenarios plus randomized traffic against a queue-based model.
module tb_pc_gen;
  localparam int PCW   = 32;
  localparam int INC   = 4;
  localparam int DEPTH = 4;
`ifdef PC_GEN_RAS_EN
  localparam bit RAS_EN = 1'b1;
`else
  localparam bit RAS_EN = 1'b0;
`endif
  localparam int S_BOOT = 0;
  localparam int S_RUN  = 1;
  localparam int S_KILL = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] reset_vector, redirect_pc, pred_target;
  logic        redirect_valid, pred_valid, pred_is_call, pred_is_ret;
  logic [2:0]  ras_count;

  pc_gen_if #(.PC_WIDTH(PCW)) fetch();

  pc_gen #(.PC_WIDTH(PCW), .INC_AMOUNT(INC), .RAS_DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .reset_vector  (reset_vector),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .pred_valid    (pred_valid),
    .pred_target   (pred_target),
    .pred_is_call  (pred_is_call),
    .pred_is_ret   (pred_is_ret),
    .fetch         (fetch.master),
    .ras_count     (ras_count)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: PC, a state number and the RAS as a queue (back = top).
  logic [31:0] m_pc;
  int          m_state = S_BOOT;
  logic [31:0] m_ras[$];

  function automatic bit m_valid();
    return (m_state == S_RUN) && !redirect_valid;
  endfunction

  task automatic model_step();
    logic [31:0] seq, np;
    bit acc;
    seq = m_pc + 32'(INC);
    acc = m_valid() && fetch.pc_out_ready;
    if (!rst_n) begin
      m_pc = reset_vector;
      m_state = S_BOOT;
      m_ras.delete();
    end else if (redirect_valid) begin
      m_pc = redirect_pc;
      m_state = S_KILL;
    end else begin
      m_state = S_RUN;
      if (acc) begin
        if (RAS_EN && pred_is_ret && m_ras.size() > 0) np = m_ras.pop_back();
        else if (pred_valid) np = pred_target;
        else np = seq;
        if (RAS_EN && pred_valid && pred_is_call) begin
          m_ras.push_back(seq);
          if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
        end
        m_pc = np;
      end
    end
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    redirect_valid = 1'b0;
    redirect_pc = '0;
    pred_valid = 1'b0;
    pred_target = '0;
    pred_is_call = 1'b0;
    pred_is_ret = 1'b0;
    fetch.pc_out_ready = 1'b1;
  endtask

  task automatic goto_pc(input logic [31:0] addr);
    redirect_valid = 1'b1;
    redirect_pc = addr;
    cycle();
    redirect_valid = 1'b0;
    cycle();
  endtask

  task automatic test_reset();
    logic [31:0] exp_seq [3];
    exp_seq[0] = 32'h8000_0000;
    exp_seq[1] = 32'h8000_0004;
    exp_seq[2] = 32'h8000_0008;
    idle();
    rst_n = 1'b0;
    reset_vector = 32'h8000_0000;
    cycle();
    cycle();
    n_tests++;
    if (fetch.pc_out !== 32'h8000_0000 || fetch.pc_out_valid !== 1'b0 || ras_count !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_hold: pc=%h valid=%b cnt=%0d, expected pc=80000000 valid=0 cnt=0",
               fetch.pc_out, fetch.pc_out_valid, ras_count);
    end
    rst_n = 1'b1;
    #1;
    n_tests++;
    if (fetch.pc_out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL boot_bubble: valid=%b, expected 0", fetch.pc_out_valid);
    end
    for (int i = 0; i < 3; i++) begin
      cycle();
      n_tests++;
      if (fetch.pc_out !== exp_seq[i] || fetch.pc_out_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL reset_seq%0d: pc=%h valid=%b, expected pc=%h valid=1",
                 i, fetch.pc_out, fetch.pc_out_valid, exp_seq[i]);
      end
    end
  endtask

  task automatic test_stall();
    goto_pc(32'h100);
    fetch.pc_out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      pred_valid = 1'b1;
      pred_target = $urandom & 32'hFFFF_FFFC;
      pred_is_call = 1'b1;
      #1;
      n_tests++;
      if (fetch.pc_out !== 32'h100 || fetch.pc_out_valid !== 1'b1 || ras_count !== 3'd0) begin
        n_fail++;
        $display("FAIL stall_hold%0d: pc=%h valid=%b cnt=%0d, expected pc=100 valid=1 cnt=0",
                 i, fetch.pc_out, fetch.pc_out_valid, ras_count);
      end
      cycle();
    end
    idle();
    cycle();
    n_tests++;
    if (fetch.pc_out !== 32'h104 || fetch.pc_out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_release: pc=%h valid=%b, expected pc=104 valid=1",
               fetch.pc_out, fetch.pc_out_valid);
    end
  endtask

  task automatic test_redirect();
    int exp_cnt;
    exp_cnt = m_ras.size();
    redirect_valid = 1'b1;
    redirect_pc = 32'h2000;
    #1;
    n_tests++;
    if (fetch.pc_out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL redirect_same_cycle: valid=%b, expected 0", fetch.pc_out_valid);
    end
    cycle();
    redirect_valid = 1'b0;
    #1;
    n_tests++;
    if (fetch.pc_out !== 32'h2000 || fetch.pc_out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL redirect_bubble: pc=%h valid=%b, expected pc=2000 valid=0",
               fetch.pc_out, fetch.pc_out_valid);
    end
    cycle();
    n_tests++;
    if (fetch.pc_out !== 32'h2000 || fetch.pc_out_valid !== 1'b1 || int'(ras_count) != exp_cnt) begin
      n_fail++;
      $display("FAIL redirect_target: pc=%h valid=%b cnt=%0d, expected pc=2000 valid=1 cnt=%0d",
               fetch.pc_out, fetch.pc_out_valid, ras_count, exp_cnt);
    end
    redirect_valid = 1'b1;
    redirect_pc = 32'h3000;
    cycle();
    redirect_pc = 32'h3100;
    cycle();
    redirect_valid = 1'b0;
    #1;
    n_tests++;
    if (fetch.pc_out !== 32'h3100 || fetch.pc_out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL redirect_in_kill: pc=%h valid=%b, expected pc=3100 valid=0",
               fetch.pc_out, fetch.pc_out_valid);
    end
    cycle();
    n_tests++;
    if (fetch.pc_out !== 32'h3100 || fetch.pc_out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL redirect_kill_exit: pc=%h valid=%b, expected pc=3100 valid=1",
               fetch.pc_out, fetch.pc_out_valid);
    end
  endtask

  task automatic test_call_ret();
    idle();
    goto_pc(32'h40);
    pred_valid = 1'b1;
    pred_is_call = 1'b1;
    pred_target = 32'h400;
    cycle();
    idle();
    n_tests++;
    if (fetch.pc_out !== 32'h400 || ras_count !== 3'(RAS_EN ? 1 : 0)) begin
      n_fail++;
      $display("FAIL call_target: pc=%h cnt=%0d, expected pc=400 cnt=%0d",
               fetch.pc_out, ras_count, RAS_EN ? 1 : 0);
    end
    pred_is_ret = 1'b1;
    cycle();
    idle();
    n_tests++;
    if (fetch.pc_out !== (RAS_EN ? 32'h44 : 32'h404) || ras_count !== 3'd0) begin
      n_fail++;
      $display("FAIL ret_target: pc=%h cnt=%0d, expected pc=%h cnt=0",
               fetch.pc_out, ras_count, RAS_EN ? 32'h44 : 32'h404);
    end
  endtask

  task automatic test_ras_overflow();
    logic [31:0] rets [4];
    logic [31:0] exp_pc;
    rets[0] = 32'h54; rets[1] = 32'h44; rets[2] = 32'h34; rets[3] = 32'h24;
    idle();
    goto_pc(32'h10);
    for (int i = 1; i <= 5; i++) begin
      pred_valid = 1'b1;
      pred_is_call = 1'b1;
      pred_target = (i < 5) ? 32'((i + 1) * 16) : 32'h1000;
      cycle();
    end
    idle();
    n_tests++;
    if (fetch.pc_out !== 32'h1000 || ras_count !== 3'(RAS_EN ? 4 : 0)) begin
      n_fail++;
      $display("FAIL ras_full: pc=%h cnt=%0d, expected pc=1000 cnt=%0d",
               fetch.pc_out, ras_count, RAS_EN ? 4 : 0);
    end
    exp_pc = 32'h1000;
    for (int k = 0; k < 5; k++) begin
      pred_is_ret = 1'b1;
      exp_pc = (RAS_EN && k < 4) ? rets[k] : exp_pc + 32'd4;
      cycle();
      idle();
      n_tests++;
      if (fetch.pc_out !== exp_pc || ras_count !== 3'(RAS_EN ? ((k < 4) ? 3 - k : 0) : 0)) begin
        n_fail++;
        $display("FAIL ras_ret%0d: pc=%h cnt=%0d, expected pc=%h cnt=%0d",
                 k, fetch.pc_out, ras_count, exp_pc, RAS_EN ? ((k < 4) ? 3 - k : 0) : 0);
      end
    end
  endtask

  task automatic test_ret_empty_and_combo();
    logic [31:0] base;
    idle();
    goto_pc(32'h6000);
    pred_is_ret = 1'b1;
    pred_valid = 1'b1;
    pred_target = 32'h7000;
    cycle();
    n_tests++;
    if (fetch.pc_out !== 32'h7000 || ras_count !== 3'd0) begin
      n_fail++;
      $display("FAIL ret_empty_pred: pc=%h cnt=%0d, expected pc=7000 cnt=0", fetch.pc_out, ras_count);
    end
    idle();
    pred_valid = 1'b1;
    pred_is_call = 1'b1;
    pred_target = 32'h8000;
    cycle();
    pred_is_ret = 1'b1;
    pred_target = 32'h9000;
    cycle();
    base = RAS_EN ? 32'h7004 : 32'h9000;
    n_tests++;
    if (fetch.pc_out !== base || ras_count !== 3'(RAS_EN ? 1 : 0)) begin
      n_fail++;
      $display("FAIL pop_push: pc=%h cnt=%0d, expected pc=%h cnt=%0d",
               fetch.pc_out, ras_count, base, RAS_EN ? 1 : 0);
    end
    idle();
    pred_is_ret = 1'b1;
    cycle();
    idle();
    n_tests++;
    if (fetch.pc_out !== (RAS_EN ? 32'h8004 : base + 32'd4) || ras_count !== 3'd0) begin
      n_fail++;
      $display("FAIL pop_after_replace: pc=%h cnt=%0d, expected pc=%h cnt=0",
               fetch.pc_out, ras_count, RAS_EN ? 32'h8004 : base + 32'd4);
    end
  endtask

  task automatic test_wrap();
    idle();
    goto_pc(32'hFFFF_FFFC);
    cycle();
    n_tests++;
    if (fetch.pc_out !== 32'h0 || fetch.pc_out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL wrap: pc=%h valid=%b, expected pc=00000000 valid=1", fetch.pc_out, fetch.pc_out_valid);
    end
  endtask

  task automatic test_reset_mid();
    idle();
    pred_valid = 1'b1;
    pred_is_call = 1'b1;
    pred_target = 32'h900;
    cycle();
    idle();
    reset_vector = 32'h1234_5670;
    rst_n = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 32'h4444;
    cycle();
    redirect_valid = 1'b0;
    #1;
    n_tests++;
    if (fetch.pc_out !== 32'h1234_5670 || fetch.pc_out_valid !== 1'b0 || ras_count !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_mid: pc=%h valid=%b cnt=%0d, expected pc=12345670 valid=0 cnt=0",
               fetch.pc_out, fetch.pc_out_valid, ras_count);
    end
    rst_n = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h500;
    cycle();
    redirect_valid = 1'b0;
    cycle();
    n_tests++;
    if (fetch.pc_out !== 32'h500 || fetch.pc_out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL redirect_in_boot: pc=%h valid=%b, expected pc=500 valid=1",
               fetch.pc_out, fetch.pc_out_valid);
    end
  endtask

  task automatic test_random();
    idle();
    rst_n = 1'b0;
    reset_vector = $urandom & 32'hFFFF_FFFC;
    cycle();
    rst_n = 1'b1;
    for (int i = 0; i < 400; i++) begin
      rst_n = ($urandom % 64) != 0;
      redirect_valid = ($urandom % 10) == 0;
      redirect_pc = $urandom & 32'hFFFF_FFFC;
      fetch.pc_out_ready = ($urandom % 4) != 0;
      pred_valid = ($urandom % 3) == 0;
      pred_target = $urandom & 32'hFFFF_FFFC;
      pred_is_call = pred_valid && (($urandom % 2) == 0);
      pred_is_ret = ($urandom % 3) == 0;
      #1;
      n_tests++;
      if (fetch.pc_out !== m_pc || fetch.pc_out_valid !== m_valid() || int'(ras_count) != m_ras.size()) begin
        n_fail++;
        $display("FAIL random%0d: pc=%h valid=%b cnt=%0d, expected pc=%h valid=%b cnt=%0d",
                 i, fetch.pc_out, fetch.pc_out_valid, ras_count, m_pc, m_valid(), m_ras.size());
      end
      cycle();
    end
    idle();
    rst_n = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_stall();
    test_redirect();
    test_call_ret();
    test_ras_overflow();
    test_ret_empty_and_combo();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
